cache_arbiter: RTL and testbench
================================

# cache_arbiter

Arbitrates the single line-granular physical memory port between the instruction cache (read-only) and the data cache (read/write) of the pipelined RV32I core. Each cache miss or writeback is one line transaction. The arbiter grants one requester at a time with round-robin fairness. It registers the granted request's address and write data and holds them stable downstream, then routes the memory response back to the granted cache.

## Interface
- LINE_W, 256, cache line width in bits
- ADDR_W, 32, physical address width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request; held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line writeback request; held until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- m_read  out  1  memory line read
- m_write  out  1  memory line write
- m_address  out  ADDR_W  memory line address (registered)
- m_wdata  out  LINE_W  memory write line (registered)
- m_rdata  in  LINE_W  memory read line
- m_resp  in  1  memory completion pulse

## Operation
- States:
  - IDLE: no grant.
  - SERVE_I: I-cache read in flight.
  - SERVE_D: D-cache read or write in flight.
- Registers: state, last_grant (I/D), req_addr, req_wdata, req_is_write.
- IDLE transitions:
  - i_read only -> SERVE_I; latch i_address; req_is_write=0.
  - d_read|d_write only -> SERVE_D; latch d_address and d_wdata; req_is_write=d_write.
  - Both pending -> grant the side opposite last_grant.
  - last_grant updates to the granted side on every grant.
- SERVE_x:
  - m_read = ~req_is_write; m_write = req_is_write.
  - m_address = req_addr; m_wdata = req_wdata.
  - Stays in SERVE_x until m_resp.
- On m_resp in SERVE_x:
  - x_resp=1 in the same cycle (combinational); next state IDLE.
  - Requester inputs are not sampled while in SERVE_x.
- i_rdata and d_rdata are both driven with m_rdata at all times. Caches qualify the data with their own resp.
- m_resp in IDLE is ignored. Memory must not pulse m_resp without an active m_read/m_write.
- d_read and d_write together is illegal. d_write wins (treated as a write), and a simulation assertion fires.
- Requester contract: the cache deasserts or changes its request in the cycle after resp. The arbiter re-samples in IDLE on that cycle.

## Timing
- Reset (rst=1 at a clock edge):
  - state=IDLE, last_grant=I (so the first tie grants D).
  - req_addr=0, req_wdata=0, req_is_write=0.
  - All outputs 0: m_read, m_write, m_address, m_wdata, i_resp, d_resp. The rdata outputs follow m_rdata.
- Reset mid-transaction aborts the grant. m_read/m_write drop in the cycle after the reset edge, and no resp is issued.
- Grant latency: a request present in IDLE at edge N gives m_read/m_write asserted from cycle N+1.
- Response latency: m_resp in cycle M gives x_resp in cycle M. A new grant can start at the edge ending cycle M+1, so m_* are re-asserted in cycle M+2.
- Minimum turnaround between back-to-back transactions: one IDLE cycle.
- m_address and m_wdata are constant for the whole SERVE_x interval, regardless of input changes.
- Starvation bound: a pending requester waits at most one other transaction.

## Structure
- Shared package arbiter_pkg holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - grant_t enum {GRANT_I, GRANT_D}
- Single module with no sub-modules. The round-robin choice is one comparison against last_grant.
- A cacheline adaptor (burst <-> line) sits downstream on the m_* port and is not part of this block.

## Test plan
- Lone I read: i_read=1, i_address=0x4000_0040, m_resp after 5 cycles with m_rdata=0xA5..A5 -> m_read high cycles 1-5, m_address=0x4000_0040, i_resp pulses once with i_rdata=0xA5..A5, d_resp stays 0.
- Lone D writeback: d_write=1, d_address=0x0000_1000, d_wdata=0x1234..; the cache changes d_wdata mid-transaction -> m_write=1, m_wdata holds the original value, d_resp after m_resp.
- Simultaneous first requests after reset -> D granted first. I is granted immediately after the IDLE cycle, and m_address switches to i_address.
- Sustained contention for 6 transactions -> grants alternate D, I, D, I, D, I; each gap is exactly one IDLE cycle.
- Reset asserted 2 cycles into SERVE_D -> m_write=0 the next cycle, no d_resp, state IDLE. Post-reset tie grants D.
- Spurious m_resp in IDLE -> no i_resp/d_resp, state unchanged. d_read&d_write together -> treated as a write and the assertion fires.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types for the cache memory-port arbiter.
// Holds the arbiter FSM state and the round-robin grant side.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter for the line-granular memory port shared by the
// I-cache (read only) and the D-cache (read/write).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_read, i_address     I-cache line read request (held until i_resp)
//   i_rdata, i_resp       line returned to I-cache, one-cycle done pulse
//   d_read, d_write       D-cache line read / writeback (held until d_resp)
//   d_address, d_wdata    D-cache line address and writeback line
//   d_rdata, d_resp       line returned to D-cache, one-cycle done pulse
//   m_read, m_write       memory line read / write strobes
//   m_address, m_wdata    registered request, stable for the transaction
//   m_rdata, m_resp       memory read line and completion pulse
module cache_arbiter
    import arbiter_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    arb_state_t        state;
    arb_state_t        state_nx;
    grant_t            last_grant;
    grant_t            last_grant_nx;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_addr_nx;
    logic [LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0] req_wdata_nx;
    logic              req_is_write;
    logic              req_is_write_nx;

    logic              i_req;
    logic              d_req;
    logic              pick_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // D wins when it is alone, or on a tie when I won last time.
    assign pick_d = d_req & (~i_req | (last_grant == GRANT_I));

    // Both caches see the memory line; each qualifies it with its resp.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Downstream sees only the latched copy, so cache-side changes
    // during a transaction never reach memory.
    assign m_address = req_addr;
    assign m_wdata   = req_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= GRANT_I;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_is_write <= 1'b0;
        end else begin
            state        <= state_nx;
            last_grant   <= last_grant_nx;
            req_addr     <= req_addr_nx;
            req_wdata    <= req_wdata_nx;
            req_is_write <= req_is_write_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        last_grant_nx   = last_grant;
        req_addr_nx     = req_addr;
        req_wdata_nx    = req_wdata;
        req_is_write_nx = req_is_write;
        m_read          = 1'b0;
        m_write         = 1'b0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;

        unique case (state)
            IDLE: begin
                // m_resp is ignored here: nothing is in flight.
                if (pick_d) begin
                    state_nx        = SERVE_D;
                    last_grant_nx   = GRANT_D;
                    req_addr_nx     = d_address;
                    req_wdata_nx    = d_wdata;
                    // A read+write collision is handled as a write.
                    req_is_write_nx = d_write;
                end else if (i_req) begin
                    state_nx        = SERVE_I;
                    last_grant_nx   = GRANT_I;
                    req_addr_nx     = i_address;
                    req_is_write_nx = 1'b0;
                end
            end

            SERVE_I: begin
                m_read  = ~req_is_write;
                m_write = req_is_write;
                if (m_resp) begin
                    i_resp   = 1'b1;
                    state_nx = IDLE;
                end
            end

            SERVE_D: begin
                m_read  = ~req_is_write;
                m_write = req_is_write;
                if (m_resp) begin
                    d_resp   = 1'b1;
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Simultaneous D read and write is a cache bug; flag it when sampled.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE) begin
            assert (!(d_read && d_write))
            else $warning("cache_arbiter: d_read with d_write, handled as write");
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-level reference.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          m_read;
    logic          m_write;
    logic [AW-1:0] m_address;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_rdata = '0;
    logic          m_resp = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .m_read(m_read), .m_write(m_write),
        .m_address(m_address), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_resp(m_resp)
    );

    int checks = 0;
    int errors = 0;

    // reference: who is being served (0 none, 1 I, 2 D) and the
    // transaction the memory should currently be seeing
    int            ms = 0;
    bit            ml_d = 1'b0;
    logic [AW-1:0] ma = '0;
    logic [LW-1:0] mw = '0;
    bit            mwr = 1'b0;

    int            lat = 0;
    int            lat_lo = 0;
    int            lat_hi = 0;
    bit            mem_auto = 1'b0;
    bit            mem_rand = 1'b0;
    logic [LW-1:0] mem_pat = '0;
    int            mode = 0;

    bit            i_seen = 1'b0;
    bit            d_seen = 1'b0;
    int            n_i = 0;
    int            n_d = 0;
    int            n_mread = 0;
    int            n_mwrite = 0;
    logic [LW-1:0] i_got = '0;
    logic [AW-1:0] obs_addr[$];
    int            gaps[$];
    bit            prev_act = 1'b0;
    int            idle_run = 0;
    int            i_wait = 0;
    int            d_wait = 0;
    logic [LW-1:0] orig;

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        v = '0;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = $urandom;
        return a & ~32'h3F;
    endfunction

    task automatic drive_req();
        int op;
        case (mode)
            0: begin
                if (i_seen) i_read = 1'b0;
                if (d_seen) begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
            end
            1: begin
                if (i_seen) i_address = i_address + 32'h40;
                if (d_seen) d_address = d_address + 32'h40;
            end
            2: begin
                if (i_seen) begin
                    i_read    = ($urandom_range(0, 1) == 1);
                    i_address = rnd_addr();
                end else if (!i_read && $urandom_range(0, 3) == 0) begin
                    i_read    = 1'b1;
                    i_address = rnd_addr();
                end else if (ms == 1 && $urandom_range(0, 1) == 1) begin
                    i_address = rnd_addr();
                end
                if (d_seen || (!d_read && !d_write && $urandom_range(0, 3) == 0)) begin
                    op        = int'($urandom_range(0, 2));
                    d_read    = (op == 1);
                    d_write   = (op == 2);
                    d_address = rnd_addr();
                    d_wdata   = rnd_line();
                end else if (ms == 2 && $urandom_range(0, 1) == 1) begin
                    d_address = rnd_addr();
                    d_wdata   = rnd_line();
                end
            end
            default: ;
        endcase
    endtask

    task automatic drive_mem();
        if (mem_rand) m_rdata = rnd_line();
        if (mem_auto) begin
            m_resp = 1'b0;
            if (ms != 0) begin
                if (lat == 0) begin
                    m_resp  = 1'b1;
                    m_rdata = mem_rand ? rnd_line() : mem_pat;
                end else begin
                    lat--;
                end
            end
        end
    endtask

    // one clock: check outputs at negedge, advance reference at posedge,
    // then drive the caches and memory for the next cycle
    task automatic step();
        bit ir;
        bit dr;
        bit pd;
        bit act;
        @(negedge clk);
        chk("m_read", LW'(ms != 0 && !mwr), LW'(m_read) ^ LW'(0) ? LW'(m_read) : LW'(0));
        chk("m_write", LW'(m_write), LW'(ms != 0 && mwr));
        chk("m_read_ref", LW'(m_read), LW'(ms != 0 && !mwr));
        chk("m_address", LW'(m_address), LW'(ma));
        chk("m_wdata", m_wdata, mw);
        chk("i_resp", LW'(i_resp), LW'(ms == 1 && m_resp));
        chk("d_resp", LW'(d_resp), LW'(ms == 2 && m_resp));
        chk("i_rdata", i_rdata, m_rdata);
        chk("d_rdata", d_rdata, m_rdata);
        i_seen = i_resp;
        d_seen = d_resp;
        if (i_resp) begin
            n_i++;
            i_got = i_rdata;
        end
        if (d_resp) n_d++;
        if (m_read) n_mread++;
        if (m_write) n_mwrite++;
        act = m_read | m_write;
        if (act && !prev_act) begin
            obs_addr.push_back(m_address);
            gaps.push_back(idle_run);
        end
        if (act) idle_run = 0;
        else idle_run++;
        prev_act = act;
        if (d_resp && i_read) begin
            i_wait++;
            chk("starve_i", LW'(i_wait <= 1), LW'(1));
        end
        if (i_resp) i_wait = 0;
        if (i_resp && (d_read || d_write)) begin
            d_wait++;
            chk("starve_d", LW'(d_wait <= 1), LW'(1));
        end
        if (d_resp) d_wait = 0;

        @(posedge clk);
        ir = i_read;
        dr = d_read | d_write;
        if (rst) begin
            ms = 0;
            ml_d = 1'b0;
            ma = '0;
            mw = '0;
            mwr = 1'b0;
            i_wait = 0;
            d_wait = 0;
        end else if (ms == 0) begin
            if (ir || dr) begin
                // alone, or the side that did not win the previous grant
                pd = dr && (!ir || !ml_d);
                ml_d = pd;
                ms = pd ? 2 : 1;
                ma = pd ? d_address : i_address;
                if (pd) mw = d_wdata;
                mwr = pd && d_write;
                lat = int'($urandom_range(lat_lo, lat_hi));
            end
        end else if (m_resp) begin
            ms = 0;
        end
        #1;
        drive_req();
        drive_mem();
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        gaps.delete();
        n_i = 0;
        n_d = 0;
        n_mread = 0;
        n_mwrite = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step();
        step();
        chk("rst_m_read", LW'(m_read), LW'(0));
        chk("rst_m_write", LW'(m_write), LW'(0));
        chk("rst_m_address", LW'(m_address), LW'(0));
        chk("rst_m_wdata", m_wdata, LW'(0));
        rst = 1'b0;
        step();

        // lone I-cache read, memory answers in the fifth busy cycle
        mode = 0;
        mem_auto = 1'b1;
        lat_lo = 4;
        lat_hi = 4;
        mem_pat = {32{8'hA5}};
        clear_obs();
        i_read = 1'b1;
        i_address = 32'h4000_0040;
        for (int k = 0; k < 20 && n_i == 0; k++) step();
        step();
        step();
        chk("lone_i_resp", LW'(n_i), LW'(1));
        chk("lone_i_data", i_got, {32{8'hA5}});
        chk("lone_i_busy", LW'(n_mread), LW'(5));
        chk("lone_i_dresp", LW'(n_d), LW'(0));
        chk("lone_i_nobs", LW'(obs_addr.size()), LW'(1));
        if (obs_addr.size() > 0)
            chk("lone_i_addr", LW'(obs_addr[0]), LW'(32'h4000_0040));

        // lone D writeback, the cache scribbles on d_wdata mid-flight
        clear_obs();
        lat_lo = 3;
        lat_hi = 3;
        orig = {8{32'h1234_5678}};
        d_write = 1'b1;
        d_address = 32'h0000_1000;
        d_wdata = orig;
        step();
        step();
        d_wdata = ~orig;
        d_address = 32'h0000_2FC0;
        chk("wb_m_write", LW'(m_write), LW'(1));
        chk("wb_hold_data", m_wdata, orig);
        for (int k = 0; k < 20 && n_d == 0; k++) step();
        chk("wb_d_resp", LW'(n_d), LW'(1));
        chk("wb_mwrite", LW'(n_mwrite), LW'(4));
        chk("wb_mread", LW'(n_mread), LW'(0));
        step();

        // tie straight after reset, then sustained contention
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_obs();
        mode = 1;
        lat_lo = 0;
        lat_hi = 2;
        i_read = 1'b1;
        d_read = 1'b1;
        i_address = 32'h8000_0000;
        d_address = 32'h0002_0000;
        for (int k = 0; k < 100 && !(n_i >= 3 && n_d >= 3); k++) step();
        i_read = 1'b0;
        d_read = 1'b0;
        mode = 0;
        step();
        step();
        chk("rr_count", LW'(obs_addr.size()), LW'(6));
        for (int k = 0; k < 6 && k < obs_addr.size(); k++) begin
            if (k % 2 == 0)
                chk("rr_d_addr", LW'(obs_addr[k]), LW'(32'h0002_0000 + (k / 2) * 32'h40));
            else
                chk("rr_i_addr", LW'(obs_addr[k]), LW'(32'h8000_0000 + (k / 2) * 32'h40));
            if (k > 0) chk("rr_gap", LW'(gaps[k]), LW'(1));
        end

        // reset two cycles into a D writeback
        clear_obs();
        mem_auto = 1'b0;
        m_resp = 1'b0;
        d_write = 1'b1;
        d_address = 32'h0000_2000;
        d_wdata = rnd_line();
        step();
        step();
        step();
        chk("mid_m_write", LW'(m_write), LW'(1));
        rst = 1'b1;
        d_write = 1'b0;
        step();
        chk("abort_m_write", LW'(m_write), LW'(0));
        chk("abort_m_read", LW'(m_read), LW'(0));
        rst = 1'b0;
        step();
        step();
        chk("abort_d_resp", LW'(n_d), LW'(0));
        clear_obs();
        mem_auto = 1'b1;
        lat_lo = 1;
        lat_hi = 1;
        i_read = 1'b1;
        d_read = 1'b1;
        i_address = 32'h0000_3000;
        d_address = 32'h0000_5000;
        for (int k = 0; k < 40 && !(n_i >= 1 && n_d >= 1); k++) step();
        step();
        chk("post_rst_count", LW'(obs_addr.size()), LW'(2));
        if (obs_addr.size() >= 2) begin
            chk("post_rst_first", LW'(obs_addr[0]), LW'(32'h0000_5000));
            chk("post_rst_second", LW'(obs_addr[1]), LW'(32'h0000_3000));
        end

        // spurious memory response while idle
        clear_obs();
        mem_auto = 1'b0;
        step();
        m_resp = 1'b1;
        m_rdata = rnd_line();
        step();
        m_resp = 1'b0;
        step();
        chk("spur_i_resp", LW'(n_i), LW'(0));
        chk("spur_d_resp", LW'(n_d), LW'(0));
        chk("spur_idle", LW'(m_read | m_write), LW'(0));

        // illegal read+write from the D-cache is handled as a write
        clear_obs();
        mem_auto = 1'b1;
        d_read = 1'b1;
        d_write = 1'b1;
        d_address = 32'h0000_6000;
        d_wdata = rnd_line();
        for (int k = 0; k < 20 && n_d == 0; k++) step();
        step();
        chk("both_d_resp", LW'(n_d), LW'(1));
        chk("both_mwrite", LW'(n_mwrite), LW'(2));
        chk("both_mread", LW'(n_mread), LW'(0));

        // randomized traffic against the reference
        mode = 2;
        mem_rand = 1'b1;
        lat_lo = 0;
        lat_hi = 4;
        for (int k = 0; k < 3000; k++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
